// File: rtl/execute_writeback.sv
// Execute/writeback stage: ALU, dmem port, debug-bus initiator FSM and the registered writeback path.
// Optional macro BUS_TIMEOUT_EN bounds the BUS_WAIT state to BUS_TIMEOUT cycles.
module execute_writeback #(
    parameter int          BUS_TIMEOUT  = 255,
    parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  iOpcode,
    input  logic [15:0] iImm,
    input  logic [3:0]  iSr1,
    input  logic [3:0]  iSr2,
    input  logic [15:0] iData1,
    input  logic [15:0] iData2,
    input  logic        iAlutoReg,
    input  logic        iMemtoReg,
    input  logic        iBustoReg,
    input  logic [3:0]  iWriteBackAddr,
    input  logic        iALUSrc,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iBusWrite,
    output logic        oWriteBack_en,
    output logic [3:0]  oWriteBackAddr,
    output logic [15:0] oWriteBackData,
    output logic [2:0]  oNVZ,
    output logic        oStall,
    output logic [15:0] oMemAddr,
    output logic [15:0] oMemWData,
    output logic        oMemRe,
    output logic        oMemWe,
    input  logic [15:0] iMemRData,
    output logic        oBusReq,
    output logic        oBusWrite,
    output logic [15:0] oBusAddr,
    output logic [15:0] oBusWData,
    input  logic        iBusAck,
    input  logic [15:0] iBusRData,
    output logic        oDbgState
);

    localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB   = 5'b00001, OP_AND  = 5'b00010,
                           OP_OR   = 5'b00011, OP_XOR   = 5'b00100, OP_SLL  = 5'b00110,
                           OP_IMML = 5'b01000, OP_IMMH  = 5'b01001, OP_LOAD = 5'b01010,
                           OP_DBLD = 5'b01100, OP_DBST  = 5'b01101;

    typedef enum logic {IDLE = 1'b0, BUS_WAIT = 1'b1} state_t;

    state_t      r_state;
    logic        r_wb_en;
    logic [3:0]  r_wb_addr;
    logic [15:0] r_wb_data;
    logic        r_mem_sel;
    logic [2:0]  r_nvz;
    logic        r_bus_req;
    logic        r_bus_write;
    logic [15:0] r_bus_addr;
    logic [15:0] r_bus_wdata;
    logic        r_bus_load;
    logic [3:0]  r_bus_dest;

    logic [15:0] w_a;
    logic [15:0] w_fwd2;
    logic [15:0] w_b;
    logic [15:0] w_result;
    logic [15:0] w_ea;
    logic        w_v;
    logic        w_is_alu;
    logic        w_is_db;
    logic        w_wb_ok;
    logic        w_idle;
    logic        w_timeout;

    // Forward the previous writeback (including a load's dmem data); r0 is never forwarded.
    assign w_a    = (r_wb_en && r_wb_addr == iSr1 && iSr1 != 4'd0) ? oWriteBackData : iData1;
    assign w_fwd2 = (r_wb_en && r_wb_addr == iSr2 && iSr2 != 4'd0) ? oWriteBackData : iData2;
    assign w_b    = iALUSrc ? iImm : w_fwd2;
    assign w_ea   = w_a + iImm;
    assign w_idle = (r_state == IDLE);

    assign w_is_alu = (iOpcode == OP_ADD) || (iOpcode == OP_SUB) || (iOpcode == OP_AND) ||
                      (iOpcode == OP_OR)  || (iOpcode == OP_XOR) || (iOpcode == OP_SLL);
    assign w_is_db  = w_idle && ((iOpcode == OP_DBLD) || (iOpcode == OP_DBST));
    assign w_wb_ok  = iAlutoReg && (w_is_alu || (iOpcode == OP_IMML) ||
                      (iOpcode == OP_IMMH) || (iOpcode == OP_LOAD));

    always_comb begin
        w_result = 16'h0000;
        w_v      = 1'b0;
        case (iOpcode)
            OP_ADD: begin
                w_result = w_a + w_b;
                w_v      = (w_a[15] == w_b[15]) && (w_result[15] != w_a[15]);
            end
            OP_SUB: begin
                w_result = w_a - w_b;
                w_v      = (w_a[15] != w_b[15]) && (w_result[15] != w_a[15]);
            end
            OP_AND:  w_result = w_a & w_b;
            OP_OR:   w_result = w_a | w_b;
            OP_XOR:  w_result = w_a ^ w_b;
            OP_SLL:  w_result = w_a << w_b[3:0];
            OP_IMML: w_result = iImm;
            OP_IMMH: w_result = iImm | (w_a & 16'h00FF);
            default: w_result = 16'h0000;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(BUS_TIMEOUT + 1);
    logic [CW-1:0] r_tmo_cnt;

    assign w_timeout = (r_state == BUS_WAIT) && (r_tmo_cnt == CW'(BUS_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == BUS_WAIT && !iBusAck && !w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= 4'd0;
            r_wb_data   <= 16'h0000;
            r_mem_sel   <= 1'b0;
            r_nvz       <= 3'b000;
            r_bus_req   <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_addr  <= 16'h0000;
            r_bus_wdata <= 16'h0000;
            r_bus_load  <= 1'b0;
            r_bus_dest  <= 4'd0;
        end else begin
            r_wb_en   <= 1'b0;
            r_mem_sel <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_is_db) begin
                        r_bus_req   <= 1'b1;
                        r_bus_addr  <= w_ea;
                        r_bus_wdata <= w_fwd2;
                        r_bus_write <= iBusWrite;
                        r_bus_load  <= (iOpcode == OP_DBLD) && iAlutoReg;
                        r_bus_dest  <= iWriteBackAddr;
                        r_state     <= BUS_WAIT;
                    end else if (w_wb_ok) begin
                        r_wb_en   <= 1'b1;
                        r_wb_addr <= iWriteBackAddr;
                        r_wb_data <= w_result;
                        r_mem_sel <= (iOpcode == OP_LOAD) && iMemtoReg;
                    end
                    if (w_is_alu) begin
                        r_nvz <= {w_result[15], w_v, (w_result == 16'h0000)};
                    end
                end
                BUS_WAIT: begin
                    // Upstream only sends NOPs here, so instruction inputs are ignored.
                    if (iBusAck || w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_state   <= IDLE;
                        if (r_bus_load) begin
                            r_wb_en   <= 1'b1;
                            r_wb_addr <= r_bus_dest;
                            r_wb_data <= iBusAck ? iBusRData : TIMEOUT_DATA;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oStall         = w_is_db || ((r_state == BUS_WAIT) && !iBusAck);
    assign oMemAddr       = w_ea;
    assign oMemWData      = w_fwd2;
    assign oMemWe         = iMemWrite && w_idle;
    assign oMemRe         = iMemRead && !iMemWrite && w_idle;
    assign oWriteBack_en  = r_wb_en;
    assign oWriteBackAddr = r_wb_addr;
    assign oWriteBackData = r_mem_sel ? iMemRData : r_wb_data;
    assign oNVZ           = r_nvz;
    assign oBusReq        = r_bus_req;
    assign oBusWrite      = r_bus_write;
    assign oBusAddr       = r_bus_addr;
    assign oBusWData      = r_bus_wdata;
    assign oDbgState      = r_state;

    logic w_unused;
    assign w_unused = iBustoReg;

endmodule
